// File: rtl/banco_registradores_param.sv
`default_nettype none
// ============================================================================
// Module      : banco_registradores_param
// Description : Parametrised register file for the MIPS datapath. One write
//               port, two registered read ports with same-cycle write bypass,
//               optional hardwired-zero register 0, and a per-register busy
//               scoreboard for write-in-flight tracking.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W       register width in bits
//   ADDR_W       address width; depth = 2**ADDR_W
//   ZERO_REG     1: register 0 reads as 0, ignores writes and reservations
// Ports
//   clock        clock, all state updates on rising edge
//   reset        asynchronous active-high reset
//   EscReg       write enable
//   RegW         write address
//   Dado_Escrito write data
//   ReadA/ReadB  read addresses
//   LerEn        read capture enable (0 holds OutA/OutB/BusyA/BusyB)
//   Reserva      mark RegRes busy
//   RegRes       register to reserve
//   OutA/OutB    registered read data
//   BusyA/BusyB  registered busy flags for ReadA/ReadB
// ============================================================================
module banco_registradores_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              EscReg,
    input  logic [ADDR_W-1:0] RegW,
    input  logic [DATA_W-1:0] Dado_Escrito,
    input  logic [ADDR_W-1:0] ReadA,
    input  logic [ADDR_W-1:0] ReadB,
    input  logic              LerEn,
    input  logic              Reserva,
    input  logic [ADDR_W-1:0] RegRes,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB,
    output logic              BusyA,
    output logic              BusyB
);

    localparam int   c_DEPTH = 1 << ADDR_W;
    localparam logic c_ZERO  = (ZERO_REG != 0);

    // Storage and scoreboard
    logic [DATA_W-1:0] r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;

    // Registered read outputs
    logic [DATA_W-1:0] r_out_a;
    logic [DATA_W-1:0] r_out_b;
    logic              r_busy_a;
    logic              r_busy_b;

    // Qualified write / reserve strobes (register 0 masked when hardwired)
    logic               w_wr_en;
    logic               w_res_en;
    logic [c_DEPTH-1:0] w_busy_next;
    logic [DATA_W-1:0]  w_rd_a;
    logic [DATA_W-1:0]  w_rd_b;

    assign w_wr_en  = EscReg  & ~(c_ZERO & (RegW   == '0));
    assign w_res_en = Reserva & ~(c_ZERO & (RegRes == '0));

    // Busy vector after this edge: clear by the write first, then the
    // reservation sets. When both hit the same register the set survives,
    // because the reservation belongs to a younger instruction.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_en) begin
            w_busy_next[RegW] = 1'b0;
        end
        if (w_res_en) begin
            w_busy_next[RegRes] = 1'b1;
        end
    end

    // Read port A with write-first bypass. The zero override comes last so a
    // dropped write to r0 cannot leak through the bypass either.
    always_comb begin
        w_rd_a = r_regs[ReadA];
        if (w_wr_en && (RegW == ReadA)) begin
            w_rd_a = Dado_Escrito;
        end
        if (c_ZERO && (ReadA == '0)) begin
            w_rd_a = '0;
        end
    end

    // Read port B, resolved independently of port A
    always_comb begin
        w_rd_b = r_regs[ReadB];
        if (w_wr_en && (RegW == ReadB)) begin
            w_rd_b = Dado_Escrito;
        end
        if (c_ZERO && (ReadB == '0)) begin
            w_rd_b = '0;
        end
    end

    // Register array
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[RegW] <= Dado_Escrito;
        end
    end

    // Scoreboard
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Read capture; holds when LerEn is low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_a  <= '0;
            r_out_b  <= '0;
            r_busy_a <= 1'b0;
            r_busy_b <= 1'b0;
        end else if (LerEn) begin
            r_out_a  <= w_rd_a;
            r_out_b  <= w_rd_b;
            r_busy_a <= w_busy_next[ReadA];
            r_busy_b <= w_busy_next[ReadB];
        end
    end

    assign OutA  = r_out_a;
    assign OutB  = r_out_b;
    assign BusyA = r_busy_a;
    assign BusyB = r_busy_b;

endmodule
`default_nettype wire

// File: doc/banco_registradores_param.md
# banco_registradores_param

Parametrised register file for the MIPS datapath, replacing the fixed 32×32 bank. It has one write port, two registered read ports with same-cycle write bypass, and an optional hardwired-zero register. A per-register busy scoreboard lets the decode/hazard logic detect reads of registers that still have a write in flight. It sits between decode (read addresses, reservations) and write-back (write port).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and reservations

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- EscReg  in  1  write enable
- RegW  in  ADDR_W  write address
- Dado_Escrito  in  DATA_W  write data
- ReadA  in  ADDR_W  read address, port A
- ReadB  in  ADDR_W  read address, port B
- LerEn  in  1  read capture enable; 0 holds OutA/OutB/BusyA/BusyB
- Reserva  in  1  mark register RegRes busy (write in flight)
- RegRes  in  ADDR_W  register to reserve
- OutA  out  DATA_W  registered read data, port A
- OutB  out  DATA_W  registered read data, port B
- BusyA  out  1  registered busy flag for ReadA
- BusyB  out  1  registered busy flag for ReadB

## Operation
- Storage: 2**ADDR_W × DATA_W flops plus a 2**ADDR_W busy vector. No latches, no negative-phase logic.
- Write: on a rising edge with EscReg=1, regfile[RegW] <= Dado_Escrito and busy[RegW] <= 0.
- Reserve: on a rising edge with Reserva=1, busy[RegRes] <= 1.
- Same edge, Reserva=1, EscReg=1, RegRes==RegW: the write lands and busy ends at 1. The set wins because a younger instruction owns the reservation.
- Read: on a rising edge with LerEn=1:
  - OutA <= (EscReg && RegW==ReadA) ? Dado_Escrito : regfile[ReadA], giving write-first bypass. Port B works the same way.
  - BusyA <= busy_next[ReadA], where busy_next is the busy vector after this edge's clear and set. BusyB works the same way.
- LerEn=0: read outputs hold. Writes and reservations still take effect.
- ZERO_REG=1:
  - A write to address 0 is dropped, including through the bypass path.
  - Reads of address 0 return 0 with busy 0.
  - Reserva on address 0 is ignored.
- ZERO_REG=0: register 0 is an ordinary register.
- Both read ports may address the same register, and either may match RegW. Each port resolves independently.
- Reading an address with busy=1 still returns the current stored or bypassed value. Stalling is the consumer's decision.

## Timing
- Reset values: every regfile entry 0, every busy bit 0, OutA=OutB=0, BusyA=BusyB=0.
- Reset takes effect asynchronously on assertion. The first update happens on the first rising edge after deassertion.
- Read latency is 1 cycle: an address presented before edge N appears on OutA/OutB after edge N.
- Write-to-read latency is 0 extra cycles: data written at edge N is visible on the outputs after edge N when read at the same edge (bypass).
- Reserve-to-busy: Reserva at edge N makes BusyA=1 after edge N if ReadA==RegRes and LerEn=1.
- Reset asserted mid-operation: all pending state is discarded and all outputs go to 0 at once. Writes and reservations coinciding with reset are lost.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert reset asynchronously mid-cycle -> OutA/OutB/BusyA/BusyB are 0 immediately. After release, reading r5 returns 0x00000000.
- Write then read: write 0x12345678 to r7 at edge 1, read r7 on A and B at edge 2 -> OutA=OutB=0x12345678 after edge 2.
- Bypass with both ports on the written register: EscReg=1, RegW=9, Dado_Escrito=0xA5A5A5A5, ReadA=ReadB=9 at the same edge -> OutA=OutB=0xA5A5A5A5 after that edge.
- Scoreboard:
  - Reserva r3 at edge 1 -> BusyA=1 on read of r3 after edge 1.
  - Write r3 at edge 4 -> BusyA=0 and OutA=new data after edge 4.
  - Reserva and write on r3 at the same edge -> BusyA=1 and OutA=written data.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and Reserva r0 while reading r0 at the same edge -> OutA=0 and BusyA=0, and stays 0 on later reads.
- Hold and parameters: LerEn=0 while r2 is written -> OutA keeps its old value; raise LerEn -> new value. Repeat key cases with DATA_W=16, ADDR_W=3, ZERO_REG=0: r0 stores 0x00FF, and address 7 is the top entry.
